// File: rtl/char_buf_term_ctrl.sv
// Terminal-style write controller for the 13x6 text character buffer: decodes the UART byte stream
// into cursor moves and buffer writes, and runs the clear and scroll sequences.
module char_buf_term_ctrl #(
    parameter int unsigned COLS       = 13,
    parameter int unsigned ROWS       = 6,
    parameter int unsigned ROW_STRIDE = 16,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic       CLK_50MHz,
    input  logic       RESET,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       BUF_WE,
    output logic [6:0] BUF_WA,
    output logic [7:0] BUF_WD,
    output logic [6:0] BUF_RA,
    input  logic [7:0] BUF_RD,
    output logic [2:0] CURSOR_ROW,
    output logic [3:0] CURSOR_COL,
    output logic       BUSY
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned COL_W  = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'((ROWS - 1) * ROW_STRIDE + COLS - 1);
    localparam logic [ADDR_W-1:0] SRC_FIRST  = ADDR_W'(ROW_STRIDE);
    localparam logic [ADDR_W-1:0] BLANK_BASE = ADDR_W'((ROWS - 1) * ROW_STRIDE);
    localparam logic [ADDR_W-1:0] ROW_SKIP   = ADDR_W'(ROW_STRIDE - COLS + 1);
    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(ROW_STRIDE);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);

    localparam logic [DATA_W-1:0] CH_BS = 8'h08;
    localparam logic [DATA_W-1:0] CH_LF = 8'h0A;
    localparam logic [DATA_W-1:0] CH_FF = 8'h0C;
    localparam logic [DATA_W-1:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL_COPY,
        SCROLL_BLANK
    } state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  cnt, cnt_d;
    logic [COL_W-1:0]   scol, scol_d;
    logic [ROW_W-1:0]   row_d;
    logic [COL_W-1:0]   col_d;
    logic               we_d;
    logic [ADDR_W-1:0]  wa_d;
    logic [DATA_W-1:0]  wd_d;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  cnt_step;
    logic               printable;

    assign IN_READY  = (state == IDLE) && !RESET;
    assign BUSY      = (state != IDLE);
    assign BUF_RA    = (state == SCROLL_COPY) ? cnt : '0;
    assign cur_addr  = ADDR_W'(CURSOR_ROW) * STRIDE_A + ADDR_W'(CURSOR_COL);
    assign printable = (IN_DATA >= 8'h20) && (IN_DATA <= 8'h7E);
    // Scroll walks visible columns only, hopping over the unused tail of each row.
    assign cnt_step  = (scol == LAST_COL) ? cnt + ROW_SKIP : cnt + ADDR_W'(1);

    // State and registered outputs
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            scol       <= '0;
            CURSOR_ROW <= '0;
            CURSOR_COL <= '0;
            BUF_WE     <= 1'b0;
            BUF_WA     <= '0;
            BUF_WD     <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            scol       <= scol_d;
            CURSOR_ROW <= row_d;
            CURSOR_COL <= col_d;
            BUF_WE     <= we_d;
            BUF_WA     <= wa_d;
            BUF_WD     <= wd_d;
        end
    end

    // Byte decode, clear and scroll sequencing
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        scol_d  = scol;
        row_d   = CURSOR_ROW;
        col_d   = CURSOR_COL;
        we_d    = 1'b0;
        wa_d    = BUF_WA;
        wd_d    = BUF_WD;

        unique case (state)
            IDLE: begin
                if (IN_VALID) begin
                    if (printable) begin
                        we_d = 1'b1;
                        wa_d = cur_addr;
                        wd_d = IN_DATA;
                        if (CURSOR_COL == LAST_COL) begin
                            col_d = '0;
                            if (CURSOR_ROW == LAST_ROW) begin
                                state_d = SCROLL_COPY;
                                cnt_d   = SRC_FIRST;
                                scol_d  = '0;
                            end else begin
                                row_d = CURSOR_ROW + ROW_W'(1);
                            end
                        end else begin
                            col_d = CURSOR_COL + COL_W'(1);
                        end
                    end else if (IN_DATA == CH_LF) begin
                        col_d = '0;
                        if (CURSOR_ROW == LAST_ROW) begin
                            state_d = SCROLL_COPY;
                            cnt_d   = SRC_FIRST;
                            scol_d  = '0;
                        end else begin
                            row_d = CURSOR_ROW + ROW_W'(1);
                        end
                    end else if (IN_DATA == CH_CR) begin
                        col_d = '0;
                    end else if (IN_DATA == CH_BS) begin
                        if (CURSOR_COL != '0) begin
                            col_d = CURSOR_COL - COL_W'(1);
                            we_d  = 1'b1;
                            wa_d  = cur_addr - ADDR_W'(1);
                            wd_d  = FILL_CHAR;
                        end
                    end else if (IN_DATA == CH_FF) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end
                end
            end

            CLEAR: begin
                we_d = 1'b1;
                wa_d = cnt;
                wd_d = FILL_CHAR;
                if (cnt == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt + ADDR_W'(1);
                end
            end

            SCROLL_COPY: begin
                we_d = 1'b1;
                wa_d = cnt - STRIDE_A;
                wd_d = BUF_RD;
                if (cnt == LAST_ADDR) begin
                    state_d = SCROLL_BLANK;
                    cnt_d   = BLANK_BASE;
                    scol_d  = '0;
                end else begin
                    cnt_d  = cnt_step;
                    scol_d = (scol == LAST_COL) ? '0 : scol + COL_W'(1);
                end
            end

            SCROLL_BLANK: begin
                we_d = 1'b1;
                wa_d = cnt;
                wd_d = FILL_CHAR;
                if (cnt == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    scol_d  = '0;
                    row_d   = LAST_ROW;
                    col_d   = '0;
                end else begin
                    cnt_d  = cnt + ADDR_W'(1);
                    scol_d = scol + COL_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_char_buf_term_ctrl.sv
// Directed self-checking bench for char_buf_term_ctrl with a behavioural 128x8 buffer
// (synchronous write, asynchronous read).
module tb_char_buf_term_ctrl;

    logic       CLK_50MHz = 1'b0;
    logic       RESET;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic       BUF_WE;
    logic [6:0] BUF_WA;
    logic [7:0] BUF_WD;
    logic [6:0] BUF_RA;
    logic [7:0] BUF_RD;
    logic [2:0] CURSOR_ROW;
    logic [3:0] CURSOR_COL;
    logic       BUSY;

    logic [7:0] mem [0:127];
    logic       preload;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] wa_log [0:255];
    logic [7:0] wd_log [0:255];

    always #10 CLK_50MHz = ~CLK_50MHz;

    char_buf_term_ctrl dut (
        .CLK_50MHz (CLK_50MHz),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .BUF_WE    (BUF_WE),
        .BUF_WA    (BUF_WA),
        .BUF_WD    (BUF_WD),
        .BUF_RA    (BUF_RA),
        .BUF_RD    (BUF_RD),
        .CURSOR_ROW(CURSOR_ROW),
        .CURSOR_COL(CURSOR_COL),
        .BUSY      (BUSY)
    );

    // Buffer model; preload fills mem[a] = a + 0x32 so mem[16] = 0x42.
    always @(posedge CLK_50MHz) begin
        if (preload) begin
            for (int a = 0; a < 128; a++) mem[a] <= 8'(a) + 8'h32;
        end else if (BUF_WE) begin
            mem[BUF_WA] <= BUF_WD;
        end
    end
    assign BUF_RD = mem[BUF_RA];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] b);
        @(negedge CLK_50MHz);
        check("in_ready_before_send", 32'(IN_READY), 32'd1);
        IN_DATA  = b;
        IN_VALID = 1'b1;
        @(negedge CLK_50MHz);
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
    endtask

    task automatic check_cursor(input string tag, input int r, input int c);
        check({tag, "_row"}, 32'(CURSOR_ROW), 32'(r));
        check({tag, "_col"}, 32'(CURSOR_COL), 32'(c));
    endtask

    // Log writes from the current negedge until BUSY and BUF_WE are both low.
    task automatic collect(input int max_cyc, output int busy_n, output int nw, output int rdy_busy);
        bit done;
        busy_n = 0; nw = 0; rdy_busy = 0; done = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!BUSY && !BUF_WE) begin
                done = 1;
                break;
            end
            if (BUSY) busy_n++;
            if (BUSY && IN_READY) rdy_busy++;
            if (BUF_WE && nw < 256) begin
                wa_log[nw] = BUF_WA;
                wd_log[nw] = BUF_WD;
                nw++;
            end
            @(negedge CLK_50MHz);
        end
        check("collect_terminated", 32'(done), 32'd1);
    endtask

    // Expected scroll write k (0..77) with the a+0x32 preload.
    function automatic logic [14:0] scroll_exp(input int k);
        int src;
        if (k < 65) begin
            src = (1 + k / 13) * 16 + (k % 13);
            return {7'(src - 16), 8'(src + 8'h32)};
        end
        return {7'(80 + k - 65), 8'h20};
    endfunction

    initial begin
        int busy_n, nw, rdy_busy, errs, cnt;
        RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = 8'h00; preload = 1'b0;
        repeat (3) @(negedge CLK_50MHz);
        RESET = 1'b0;
        #1;
        check("rst_we", 32'(BUF_WE), 32'd0);
        check("rst_wa", 32'(BUF_WA), 32'd0);
        check("rst_wd", 32'(BUF_WD), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_ready", 32'(IN_READY), 32'd1);
        check_cursor("rst_cursor", 0, 0);

        // First printable
        send(8'h41);
        check("t1_we", 32'(BUF_WE), 32'd1);
        check("t1_wa", 32'(BUF_WA), 32'd0);
        check("t1_wd", 32'(BUF_WD), 32'h41);
        check_cursor("t1_cursor", 0, 1);
        @(negedge CLK_50MHz);
        check("t1_we_one_cycle", 32'(BUF_WE), 32'd0);

        // Wrap at end of row
        for (int i = 1; i < 13; i++) send(8'(8'h41 + i));
        check("t2_last_wa", 32'(BUF_WA), 32'd12);
        check("t2_last_wd", 32'(BUF_WD), 32'h4D);
        check_cursor("t2_wrap_cursor", 1, 0);
        send(8'h4E);
        check("t2_14th_wa", 32'(BUF_WA), 32'd16);
        check_cursor("t2_14th_cursor", 1, 1);

        // LF scroll from (5,4)
        send(8'h0D);
        check("cr_no_write", 32'(BUF_WE), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h0A);
        for (int i = 0; i < 4; i++) send(8'h78);
        check_cursor("t3_pre_cursor", 5, 4);
        @(negedge CLK_50MHz); preload = 1'b1;
        @(negedge CLK_50MHz); preload = 1'b0;
        check("t3_preload16", 32'(mem[16]), 32'h42);
        send(8'h0A);
        check("t3_lf_no_write", 32'(BUF_WE), 32'd0);
        collect(200, busy_n, nw, rdy_busy);
        check("t3_busy_cycles", 32'(busy_n), 32'd78);
        check("t3_writes", 32'(nw), 32'd78);
        check("t3_ready_while_busy", 32'(rdy_busy), 32'd0);
        check("t3_first_wa", 32'(wa_log[0]), 32'd0);
        check("t3_first_wd", 32'(wd_log[0]), 32'h42);
        check("t3_blank0_wa", 32'(wa_log[65]), 32'd80);
        check("t3_last_wa", 32'(wa_log[77]), 32'd92);
        check("t3_last_wd", 32'(wd_log[77]), 32'h20);
        errs = 0;
        for (int k = 0; k < 78 && k < nw; k++)
            if ({wa_log[k], wd_log[k]} !== scroll_exp(k)) errs++;
        check("t3_seq_errors", 32'(errs), 32'd0);
        check_cursor("t3_post_cursor", 5, 0);
        check("t3_mem76", 32'(mem[76]), 32'h8E);
        check("t3_mem13_untouched", 32'(mem[13]), 32'h3F);
        check("t3_mem93_untouched", 32'(mem[93]), 32'h8F);

        // Form feed clear
        send(8'h0C);
        collect(200, busy_n, nw, rdy_busy);
        check("t5_busy_cycles", 32'(busy_n), 32'd93);
        check("t5_writes", 32'(nw), 32'd93);
        check("t5_ready_while_busy", 32'(rdy_busy), 32'd0);
        errs = 0;
        for (int k = 0; k < 93 && k < nw; k++)
            if (wa_log[k] !== 7'(k) || wd_log[k] !== 8'h20) errs++;
        check("t5_seq_errors", 32'(errs), 32'd0);
        check_cursor("t5_cursor", 0, 0);
        check("t5_ready", 32'(IN_READY), 32'd1);

        // Backspace, CR and ignored bytes
        send(8'h0A); send(8'h0A);
        send(8'h08);
        check("t4_bs_col0_no_write", 32'(BUF_WE), 32'd0);
        check_cursor("t4_bs_col0_cursor", 2, 0);
        send(8'h7E); send(8'h20); send(8'h61);
        check("t4_char_wa", 32'(BUF_WA), 32'd34);
        check("t4_char_wd", 32'(BUF_WD), 32'h61);
        send(8'h08);
        check("t4_bs_we", 32'(BUF_WE), 32'd1);
        check("t4_bs_wa", 32'(BUF_WA), 32'd34);
        check("t4_bs_wd", 32'(BUF_WD), 32'h20);
        check_cursor("t4_bs_cursor", 2, 2);
        send(8'h7F);
        check("ign_7f_no_write", 32'(BUF_WE), 32'd0);
        check_cursor("ign_7f_cursor", 2, 2);
        send(8'h0D);
        check("t4_cr_no_write", 32'(BUF_WE), 32'd0);
        check_cursor("t4_cr_cursor", 2, 0);

        // Printable at (5,12) writes then scrolls
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 12; i++) send(8'h30);
        check_cursor("wrap_pre_cursor", 5, 12);
        send(8'h5A);
        check("wrap_we", 32'(BUF_WE), 32'd1);
        check("wrap_wa", 32'(BUF_WA), 32'd92);
        check("wrap_wd", 32'(BUF_WD), 32'h5A);
        check("wrap_busy", 32'(BUSY), 32'd1);
        collect(200, busy_n, nw, rdy_busy);
        check("wrap_busy_cycles", 32'(busy_n), 32'd78);
        check("wrap_writes", 32'(nw), 32'd79);
        check("wrap_row4_col12", 32'(mem[76]), 32'h5A);
        check_cursor("wrap_post_cursor", 5, 0);

        // Reset in the middle of SCROLL_COPY
        send(8'h0A);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 20; i++) begin
            if (BUF_WE) cnt++;
            if (cnt < 20) @(negedge CLK_50MHz);
        end
        check("t6_reached_write20", 32'(cnt), 32'd20);
        RESET = 1'b1;
        @(negedge CLK_50MHz);
        check("t6_we", 32'(BUF_WE), 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
        check_cursor("t6_cursor", 0, 0);
        RESET = 1'b0;
        #1;
        check("t6_ready", 32'(IN_READY), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_50MHz);
            if (BUF_WE) cnt++;
        end
        check("t6_no_further_writes", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
